// File: rtl/usb_utmi_pkg.sv
// Shared types and constants for the UTMI Full-Speed transmit path.
package usb_utmi_pkg;

    typedef logic [1:0] utmi_op_mode_t;
    typedef logic [7:0] bus8_t;

    localparam utmi_op_mode_t OPM_NORMAL      = 2'b00;
    localparam utmi_op_mode_t OPM_NON_DRIVING = 2'b01;
    localparam utmi_op_mode_t OPM_RAW         = 2'b10;

    // SYNC pattern, sent LSB-first: seven 0s followed by a 1.
    localparam bus8_t USB_SYNC_BYTE   = 8'h80;
    localparam int    USB_STUFF_LIMIT = 6;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SYNC,
        ST_DATA,
        ST_EOP_SE0,
        ST_EOP_J
    } utmi_tx_state_t;

endpackage

// File: rtl/usb_tx_bit_enc.sv
// Per-bit line encoder: NRZI level, consecutive-ones counter and stuff request.
// In bypass mode the bit drives the line directly (1 -> J, 0 -> K) and no stuffing occurs.
module usb_tx_bit_enc
    import usb_utmi_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic start_i,
    input  logic bypass_i,
    input  logic bit_vld_i,
    input  logic bit_i,
    output logic level_d_o,
    output logic stuff_req_o
);
    logic       level_q;
    logic [2:0] ones_q;
    logic       level_base;
    logic [2:0] ones_base;
    logic [2:0] ones_d;

    // Next line level and ones count for the bit being issued; a packet starts from J.
    always_comb begin
        level_base = start_i ? 1'b1 : level_q;
        ones_base  = start_i ? 3'd0 : ones_q;
        level_d_o  = level_base;
        ones_d     = 3'd0;
        if (bypass_i) begin
            level_d_o = bit_i;
        end else begin
            level_d_o = bit_i ? level_base : !level_base;
            ones_d    = bit_i ? ones_base + 3'd1 : 3'd0;
        end
    end

    assign stuff_req_o = !bypass_i && (ones_q == 3'(USB_STUFF_LIMIT));

    // Commit encoder state whenever a new bit (data, SYNC or stuff) goes on the line.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            level_q <= 1'b1;
            ones_q  <= 3'd0;
        end else if (bit_vld_i) begin
            level_q <= level_d_o;
            ones_q  <= ones_d;
        end
    end

endmodule

// File: rtl/usb_utmi_tx.sv
// UTMI Full-Speed transmit path: SYNC, LSB-first serialiser, bit stuffing, NRZI and EOP.
module usb_utmi_tx
    import usb_utmi_pkg::*;
#(
    parameter int CLK_PER_BIT = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  utmi_op_mode_t op_mode,
    input  bus8_t         data_in,
    input  logic          tx_valid,
    output logic          tx_ready,
    output logic          tx_dp,
    output logic          tx_dn,
    output logic          tx_oe
);
    localparam int            CW        = (CLK_PER_BIT > 1) ? $clog2(CLK_PER_BIT) : 1;
    localparam logic [CW-1:0] CNT_LAST  = CW'(CLK_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_READY = CW'(CLK_PER_BIT - 2);

    utmi_tx_state_t state_q;
    logic [CW-1:0]  clk_cnt_q;
    logic [2:0]     bit_idx_q;
    logic           eop_bit_q;
    bus8_t          shift_q;
    utmi_op_mode_t  mode_q;
    logic           ready_q;
    logic           dp_q;
    logic           dn_q;
    logic           oe_q;

    logic in_ser;
    logic bit_end;
    logic start;
    logic bypass;
    logic stuff_req;
    logic issue;
    logic enc_bit;
    logic level_d;

    assign in_ser  = (state_q == ST_SYNC) || (state_q == ST_DATA);
    assign bit_end = (clk_cnt_q == CNT_LAST);
    assign start   = (state_q == ST_IDLE) && tx_valid && (op_mode != OPM_NON_DRIVING);
    // At packet start the mode register is not loaded yet, so use the live input.
    assign bypass  = (state_q == ST_IDLE) ? (op_mode == OPM_RAW) : (mode_q == OPM_RAW);

    assign tx_ready = ready_q;
    assign tx_dp    = dp_q;
    assign tx_dn    = dn_q;
    assign tx_oe    = oe_q;

    // Select the next bit to put on the line: first SYNC bit, stuff bit, next data bit or next byte.
    always_comb begin
        issue   = 1'b0;
        enc_bit = 1'b0;
        if (start) begin
            issue   = 1'b1;
            enc_bit = USB_SYNC_BYTE[0];
        end else if (in_ser && bit_end) begin
            if (stuff_req) begin
                issue   = 1'b1;
                enc_bit = 1'b0;
            end else if (bit_idx_q != 3'd7) begin
                issue   = 1'b1;
                enc_bit = shift_q[bit_idx_q + 3'd1];
            end else if (tx_valid) begin
                issue   = 1'b1;
                enc_bit = data_in[0];
            end
        end
    end

    usb_tx_bit_enc u_enc (
        .clk        (clk),
        .rst        (rst),
        .start_i    (start),
        .bypass_i   (bypass),
        .bit_vld_i  (issue),
        .bit_i      (enc_bit),
        .level_d_o  (level_d),
        .stuff_req_o(stuff_req)
    );

    // Packet sequencer with registered line, enable and handshake outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            clk_cnt_q <= '0;
            bit_idx_q <= 3'd0;
            eop_bit_q <= 1'b0;
            shift_q   <= USB_SYNC_BYTE;
            mode_q    <= OPM_NORMAL;
            ready_q   <= 1'b0;
            dp_q      <= 1'b1;
            dn_q      <= 1'b0;
            oe_q      <= 1'b0;
        end else begin
            ready_q   <= 1'b0;
            clk_cnt_q <= bit_end ? '0 : clk_cnt_q + 1'b1;
            case (state_q)
                ST_IDLE: begin
                    clk_cnt_q <= '0;
                    dp_q      <= 1'b1;
                    dn_q      <= 1'b0;
                    oe_q      <= 1'b0;
                    if (start) begin
                        mode_q    <= op_mode;
                        shift_q   <= USB_SYNC_BYTE;
                        bit_idx_q <= 3'd0;
                        oe_q      <= 1'b1;
                        state_q   <= ST_SYNC;
                    end
                end
                ST_SYNC, ST_DATA: begin
                    // Pulse ready on the final clk of a byte's last bit (or its trailing stuff bit).
                    ready_q <= (clk_cnt_q == CNT_READY) && !stuff_req && (bit_idx_q == 3'd7);
                    if (bit_end && !stuff_req) begin
                        if (bit_idx_q != 3'd7) begin
                            bit_idx_q <= bit_idx_q + 3'd1;
                        end else if (tx_valid) begin
                            shift_q   <= data_in;
                            bit_idx_q <= 3'd0;
                            state_q   <= ST_DATA;
                        end else begin
                            eop_bit_q <= 1'b0;
                            dp_q      <= 1'b0;
                            dn_q      <= 1'b0;
                            state_q   <= ST_EOP_SE0;
                        end
                    end
                end
                ST_EOP_SE0: begin
                    if (bit_end) begin
                        eop_bit_q <= 1'b1;
                        if (eop_bit_q) begin
                            dp_q    <= 1'b1;
                            dn_q    <= 1'b0;
                            state_q <= ST_EOP_J;
                        end
                    end
                end
                ST_EOP_J: begin
                    if (bit_end) begin
                        oe_q    <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
            if (issue) begin
                dp_q <= level_d;
                dn_q <= !level_d;
            end
        end
    end

endmodule
